// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among N requesters.
// Optional packet locking is enabled with `define ARB_PKT_LOCK_EN.
module fifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N*WIDTH-1:0]   req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  output logic                 fifo_winc,
  output logic [WIDTH-1:0]     fifo_wdata,
  input  logic                 fifo_wfull,
  output logic [IW-1:0]        grant_id,
  output logic [CNT_W-1:0]     wr_count
);

  logic             winc_q, winc_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [N-1:0]     elig;
  logic             found;
  logic [IW-1:0]    winner;
  logic             drain, load_en, accept;
  logic             pkt_end;

  assign drain   = winc_q && !fifo_wfull;
  assign load_en = !winc_q || drain;

  // First eligible requester strictly after the last winner, wrapping modulo N.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  assign accept    = found && load_en && !rst;
  assign req_ready = accept ? (N'(1) << winner) : '0;

`ifdef ARB_PKT_LOCK_EN
  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;
  state_t        state_q, state_d;
  logic [IW-1:0] lock_id_q, lock_id_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    if (accept) begin
      if (state_q == ARB && !req_last[winner]) begin
        state_d   = LOCK;
        lock_id_d = winner;
      end else if (state_q == LOCK && req_last[winner]) begin
        state_d = ARB;
      end
    end
  end

  // While locked only the owning requester may compete, even when it is idle.
  always_comb begin
    elig = req_valid;
    if (state_q == LOCK) elig = req_valid & (N'(1) << lock_id_q);
  end

  assign pkt_end = (state_q == ARB) || req_last[winner];
`else
  logic [N-1:0] unused_req_last;
  assign unused_req_last = req_last;
  assign elig            = req_valid;
  assign pkt_end         = 1'b1;
`endif

  always_comb begin
    winc_d  = winc_q;
    wdata_d = wdata_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (drain) begin
      winc_d = 1'b0;
      cnt_d  = cnt_q + CNT_W'(1);
    end
    if (accept) begin
      winc_d  = 1'b1;
      wdata_d = req_data[int'(winner)*WIDTH +: WIDTH];
      grant_d = winner;
      if (pkt_end) ptr_d = winner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      winc_q  <= 1'b0;
      wdata_q <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= IW'(N - 1);
    end else begin
      winc_q  <= winc_d;
      wdata_q <= wdata_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign fifo_winc  = winc_q;
  assign fifo_wdata = wdata_q;
  assign grant_id   = grant_q;
  assign wr_count   = cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (N=4, WIDTH=8); a second
// instance with CNT_W=4 shares the stimulus to exercise counter wrap.
module tb_fifo_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic        fifo_wfull;
  logic [3:0]  req_ready, req_ready2;
  logic        fifo_winc, fifo_winc2;
  logic [7:0]  fifo_wdata, fifo_wdata2;
  logic [1:0]  grant_id, grant_id2;
  logic [15:0] wr_count;
  logic [3:0]  wr_count2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N(4), .WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_winc(fifo_winc),
    .fifo_wdata(fifo_wdata), .fifo_wfull(fifo_wfull), .grant_id(grant_id),
    .wr_count(wr_count));

  fifo_wr_arbiter #(.N(4), .WIDTH(8), .CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready2), .fifo_winc(fifo_winc2),
    .fifo_wdata(fifo_wdata2), .fifo_wfull(fifo_wfull), .grant_id(grant_id2),
    .wr_count(wr_count2));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp1[5] = '{0, 1, 2, 3, 0};
`ifdef ARB_PKT_LOCK_EN
  int exp5[5] = '{1, 1, 1, 2, 0};
`else
  int exp5[5] = '{1, 2, 0, 1, 2};
`endif

  initial begin
    int beats1;
    rst = 1'b1; req_valid = '0; req_data = 32'hA3A2A1A0; req_last = '0; fifo_wfull = 1'b0;
    tick();
    req_valid = 4'hF;
    #1 check_val("rst_ready", 32'(req_ready), 32'h0);
    tick();
    check_val("rst_winc", 32'(fifo_winc), 32'h0);
    check_val("rst_wdata", 32'(fifo_wdata), 32'h0);
    check_val("rst_grant", 32'(grant_id), 32'h0);
    check_val("rst_count", 32'(wr_count), 32'h0);
    rst = 1'b0;

    // 1: all requesters valid, rotating grants
    for (int c = 0; c < 5; c++) begin
      #1 check_val($sformatf("t1_ready%0d", c), 32'(req_ready), 32'(4'b0001 << exp1[c]));
      tick();
      check_val($sformatf("t1_grant%0d", c), 32'(grant_id), 32'(exp1[c]));
      check_val($sformatf("t1_wdata%0d", c), 32'(fifo_wdata), 32'(8'hA0 + exp1[c]));
      check_val($sformatf("t1_winc%0d", c), 32'(fifo_winc), 32'h1);
    end
    req_valid = '0;
    tick();
    check_val("t1_idle_winc", 32'(fifo_winc), 32'h0);
    check_val("t1_count", 32'(wr_count), 32'd5);

    // 2: backpressure holds the word, then back-to-back drain+load
    req_valid = 4'b0010;
    tick();
    check_val("t2_load_grant", 32'(grant_id), 32'h1);
    fifo_wfull = 1'b1; req_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      #1 check_val($sformatf("t2_full_ready%0d", c), 32'(req_ready), 32'h0);
      tick();
      check_val($sformatf("t2_full_winc%0d", c), 32'(fifo_winc), 32'h1);
      check_val($sformatf("t2_full_wdata%0d", c), 32'(fifo_wdata), 32'hA1);
      check_val($sformatf("t2_full_count%0d", c), 32'(wr_count), 32'd5);
    end
    fifo_wfull = 1'b0;
    #1 check_val("t2_rel_ready", 32'(req_ready), 32'b0100);
    tick();
    check_val("t2_rel_count", 32'(wr_count), 32'd6);
    check_val("t2_rel_grant", 32'(grant_id), 32'h2);
    check_val("t2_rel_wdata", 32'(fifo_wdata), 32'hA2);
    req_valid = '0;
    tick();
    check_val("t2_end_count", 32'(wr_count), 32'd7);
    check_val("t2_end_winc", 32'(fifo_winc), 32'h0);

    // 3: single requester streams one word per cycle
    req_valid = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      req_data[23:16] = 8'h20 + 8'(c);
      #1 check_val($sformatf("t3_ready%0d", c), 32'(req_ready), 32'b0100);
      tick();
      check_val($sformatf("t3_grant%0d", c), 32'(grant_id), 32'h2);
      check_val($sformatf("t3_wdata%0d", c), 32'(fifo_wdata), 32'(8'h20 + c));
      check_val($sformatf("t3_count%0d", c), 32'(wr_count), 32'(7 + c));
    end
    req_valid = '0; req_data = 32'hA3A2A1A0;
    tick();
    check_val("t3_end_count", 32'(wr_count), 32'd11);
    check_val("t3_end_winc", 32'(fifo_winc), 32'h0);

    // 4: reset with a pending word, priority restarts at 0
    req_valid = 4'hF;
    tick();
    check_val("t4_pre_grant", 32'(grant_id), 32'h3);
    check_val("t4_pre_winc", 32'(fifo_winc), 32'h1);
    rst = 1'b1;
    #1 check_val("t4_rst_ready", 32'(req_ready), 32'h0);
    tick();
    check_val("t4_rst_winc", 32'(fifo_winc), 32'h0);
    check_val("t4_rst_count", 32'(wr_count), 32'h0);
    rst = 1'b0;
    #1 check_val("t4_first_ready", 32'(req_ready), 32'b0001);
    tick();
    check_val("t4_first_grant", 32'(grant_id), 32'h0);

    // 5: req1 sends a 3-beat packet while req0/req2 compete
    req_valid = 4'b0111; beats1 = 0;
    for (int c = 0; c < 5; c++) begin
      req_last = (beats1 == 2) ? 4'b0010 : 4'b0000;
      tick();
      check_val($sformatf("t5_grant%0d", c), 32'(grant_id), 32'(exp5[c]));
      check_val($sformatf("t5_wdata%0d", c), 32'(fifo_wdata), 32'(8'hA0 + exp5[c]));
      if (exp5[c] == 1) beats1++;
    end
    req_valid = '0; req_last = '0;
    tick();

    // 6: 17 drains, narrow counter wraps
    rst = 1'b1;
    tick();
    rst = 1'b0; req_valid = 4'hF;
    for (int c = 0; c < 17; c++) tick();
    check_val("t6_w4_count16", 32'(wr_count2), 32'h0);
    req_valid = '0;
    tick();
    check_val("t6_w4_count17", 32'(wr_count2), 32'h1);
    check_val("t6_w16_count17", 32'(wr_count), 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
